// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Owns the program counter and the single-outstanding request/response
//   handshake to instruction memory. It issues a fetch at PCounter and then
//   advances by 4, or loads a redirect target. It kills fetches that a
//   redirect makes stale and presents one instruction at a time to decode.
//
//   Optional feature macro: PC_ALIGN_CHECK_EN
//     When defined, a redirect to a target that is not word aligned is
//     refused. misalign_err is set and stays set until reset, and the
//     sequencer parks in IDLE after draining any outstanding request.
//     When undefined, misalign_err is tied low and targets load unchanged.
//
// Ports
//   clk, rst (async, active-low)
//   halt                              : blocks starting a new fetch
//   redirect_valid / redirect_target  : taken branch/jump and its target
//   imem_req_valid/ready, imem_addr   : request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data     : one response per accepted request
//   instr_valid/ready, instr, instr_pc: instruction presented to decode
//   PCounter                          : next fetch PC
//   busy                              : sequencer is not in IDLE
//   misalign_err                      : sticky misaligned-redirect flag
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halt,
    input  logic                   redirect_valid,
    input  logic [DATA_WIDTH-1:0]  redirect_target,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [DATA_WIDTH-1:0]  imem_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0]  instr_pc,
    output logic [DATA_WIDTH-1:0]  PCounter,
    output logic                   busy,
    output logic                   misalign_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t                  state;
    logic                    kill;
    logic [DATA_WIDTH-1:0]   req_pc;

    logic                    redir_take;
    logic                    redir_bad;
    logic                    redir_ok;
    logic                    err_stop;
    logic                    req_fire;

    // Sequential PC step; wraps naturally modulo 2^DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] seq_pc(input logic [DATA_WIDTH-1:0] pc);
        return pc + DATA_WIDTH'(4);
    endfunction

    // A redirect is ignored only while parked in IDLE with halt asserted.
    assign redir_take = redirect_valid && !(state == IDLE && halt);

`ifdef PC_ALIGN_CHECK_EN
    assign redir_bad = redir_take && (redirect_target[1:0] != 2'b00);
`else
    assign redir_bad    = 1'b0;
    assign misalign_err = 1'b0;
`endif

    assign redir_ok = redir_take && !redir_bad;
    // Once an alignment error is seen (or being raised now) no new fetch starts.
    assign err_stop = misalign_err || redir_bad;
    assign req_fire = (state == REQ) && imem_req_ready;

    assign imem_req_valid = (state == REQ);
    assign imem_addr      = PCounter;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            PCounter    <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            kill        <= 1'b0;
            req_pc      <= '0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            // Redirect target wins over the sequential increment.
            if (redir_ok)
                PCounter <= redirect_target;
            else if (req_fire && !redir_bad)
                PCounter <= seq_pc(PCounter);

            if (req_fire)
                req_pc <= PCounter;

`ifdef PC_ALIGN_CHECK_EN
            if (redir_bad)
                misalign_err <= 1'b1;
`endif

            case (state)
                IDLE: begin
                    if (!halt && !err_stop)
                        state <= REQ;
                end

                // request stage: hold the request until memory accepts it
                REQ: begin
                    if (req_fire) begin
                        state <= WAIT;
                        // The fetch just issued is already stale.
                        if (redir_take)
                            kill <= 1'b1;
                    end else if (redir_bad) begin
                        state <= IDLE;
                    end
                end

                // response stage: one response per accepted request
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill || redir_take) begin
                            kill  <= 1'b0;
                            state <= err_stop ? IDLE : REQ;
                        end else begin
                            instr       <= imem_rsp_data;
                            instr_pc    <= req_pc;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (redir_take) begin
                        kill <= 1'b1;
                    end
                end

                // presentation stage: instruction held stable for decode
                HOLD: begin
                    if (redir_take) begin
                        // Flush even if decode accepts in the same cycle.
                        instr_valid <= 1'b0;
                        state       <= redir_bad ? IDLE : REQ;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= halt ? IDLE : REQ;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed scenarios for fetch_sequencer. Expected request addresses and
//   expected delivered instructions are queued when each scenario starts; a
//   memory model checks request addresses and a decode monitor checks every
//   accepted instruction against the queues.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int DW = 16;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          halt;
    logic          redirect_valid;
    logic [DW-1:0] redirect_target;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [DW-1:0] imem_addr;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic [DW-1:0] instr_pc;
    logic [DW-1:0] PCounter;
    logic          busy;
    logic          misalign_err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int hs_count    = 0;
    int rsp_extra   = 0;
    int hs_cyc[$];

    logic [DW-1:0] exp_addr[$];
    logic [DW-1:0] exp_pc[$];
    logic [IW-1:0] exp_ins[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_sequencer #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .PCounter       (PCounter),
        .busy           (busy),
        .misalign_err   (misalign_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [DW-1:0] a, input logic [IW-1:0] d, input bit delivered);
        exp_addr.push_back(a);
        if (delivered) begin
            exp_pc.push_back(a);
            exp_ins.push_back(d);
        end
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_count < target && n < 100) begin
            tick();
            n++;
        end
        check("wait_handshake", 64'(hs_count >= target), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("wait_idle", 64'(busy), 64'd0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 100) begin
            tick();
            n++;
        end
        check("wait_instr_valid", 64'(instr_valid), 64'd1);
    endtask

    // Memory model: accepts when ready, answers rsp_extra cycles later than the
    // minimum, data word is {16'hA5A5, address}.
    initial begin : mem_model
        logic [DW-1:0] acc_addr;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst && imem_req_valid && imem_req_ready) begin
                acc_addr = imem_addr;
                if (exp_addr.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL req_addr: got request at %0h, expected no request", acc_addr);
                end else begin
                    check("req_addr", 64'(acc_addr), 64'(exp_addr.pop_front()));
                end
                @(posedge clk);
                repeat (rsp_extra) @(posedge clk);
                #1;
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = {16'hA5A5, acc_addr};
                @(posedge clk);
                #1;
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    // Decode monitor: a handshake happens on the coming edge unless a redirect flushes it.
    initial begin : decode_monitor
        forever begin
            @(negedge clk);
            if (rst && instr_valid && instr_ready && !redirect_valid) begin
                hs_count++;
                hs_cyc.push_back(cyc);
                if (exp_pc.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL instr_accept: got pc %0h data %0h, expected no instruction", instr_pc, instr);
                end else begin
                    check("instr_pc", 64'(instr_pc), 64'(exp_pc.pop_front()));
                    check("instr", 64'(instr), 64'(exp_ins.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int  base;
        bit  saw;
        rst             = 1'b0;
        halt            = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        imem_req_ready  = 1'b1;
        instr_ready     = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", 64'(PCounter), 64'h0);
        check("rst_instr_valid", 64'(instr_valid), 64'h0);
        check("rst_req_valid", 64'(imem_req_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_misalign", 64'(misalign_err), 64'h0);
        check("rst_instr", 64'(instr), 64'h0);
        check("rst_instr_pc", 64'(instr_pc), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("halted_idle", 64'(busy), 64'h0);

        // Straight-line fetch 0x0, 0x4, 0x8
        expect_fetch(16'h0000, 32'hA5A5_0000, 1'b1);
        expect_fetch(16'h0004, 32'hA5A5_0004, 1'b1);
        expect_fetch(16'h0008, 32'hA5A5_0008, 1'b1);
        halt = 1'b0;
        tick();
        wait_hs(2);
        halt = 1'b1;
        wait_idle();
        check("s1_pc", 64'(PCounter), 64'h000C);
        check("s1_hs_count", 64'(hs_cyc.size()), 64'd3);
        if (hs_cyc.size() >= 3) begin
            check("s1_gap01", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
            check("s1_gap12", 64'(hs_cyc[2] - hs_cyc[1]), 64'd3);
        end

        // Redirect while holding instruction at 0x0004
        expect_fetch(16'h0004, 32'hA5A5_0004, 1'b0);
        expect_fetch(16'h0040, 32'hA5A5_0040, 1'b1);
        instr_ready     = 1'b0;
        halt            = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 16'h0004;
        tick();
        redirect_valid = 1'b0;
        check("s2_idle_redirect_addr", 64'(imem_addr), 64'h0004);
        wait_valid();
        check("s2_hold_pc", 64'(instr_pc), 64'h0004);
        redirect_valid  = 1'b1;
        redirect_target = 16'h0040;
        instr_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        halt           = 1'b1;
        check("s2_flush_valid", 64'(instr_valid), 64'h0);
        check("s2_next_addr", 64'(imem_addr), 64'h0040);
        check("s2_req_valid", 64'(imem_req_valid), 64'h1);
        wait_idle();
        check("s2_pc", 64'(PCounter), 64'h0044);

        // Redirect while waiting for 0x0008; stale response arrives later
        rsp_extra = 2;
        expect_fetch(16'h0008, 32'hA5A5_0008, 1'b0);
        expect_fetch(16'h0100, 32'hA5A5_0100, 1'b1);
        halt            = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 16'h0008;
        tick();
        redirect_valid = 1'b0;
        halt           = 1'b1;
        tick();
        check("s3_in_wait_req", 64'(imem_req_valid), 64'h0);
        check("s3_in_wait_busy", 64'(busy), 64'h1);
        redirect_valid  = 1'b1;
        redirect_target = 16'h0100;
        tick();
        redirect_valid = 1'b0;
        check("s3_pc_loaded", 64'(PCounter), 64'h0100);
        wait_idle();
        check("s3_pc", 64'(PCounter), 64'h0104);
        rsp_extra = 0;

        // Wrap from 0xFFFC to 0x0000
        expect_fetch(16'hFFFC, 32'hA5A5_FFFC, 1'b1);
        expect_fetch(16'h0000, 32'hA5A5_0000, 1'b1);
        base            = hs_count;
        halt            = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 16'hFFFC;
        tick();
        redirect_valid = 1'b0;
        wait_hs(base + 1);
        halt = 1'b1;
        wait_idle();
        check("s4_pc_wrap", 64'(PCounter), 64'h0004);

        // Decode stalls 5 cycles, then accepts with halt set
        expect_fetch(16'h0004, 32'hA5A5_0004, 1'b1);
        instr_ready = 1'b0;
        halt        = 1'b0;
        tick();
        halt = 1'b1;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("s5_instr_stable", 64'(instr), 64'hA5A5_0004);
            check("s5_pc_stable", 64'(instr_pc), 64'h0004);
            check("s5_valid_stable", 64'(instr_valid), 64'h1);
            check("s5_no_req", 64'(imem_req_valid), 64'h0);
            tick();
        end
        check("s5_pc_before", 64'(PCounter), 64'h0008);
        instr_ready = 1'b1;
        tick();
        check("s5_busy", 64'(busy), 64'h0);
        check("s5_valid_drop", 64'(instr_valid), 64'h0);
        check("s5_pc_after", 64'(PCounter), 64'h0008);

        // Misaligned redirect to 0x0042
`ifdef PC_ALIGN_CHECK_EN
        halt            = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 16'h0042;
        tick();
        redirect_valid = 1'b0;
        check("s6_misalign_set", 64'(misalign_err), 64'h1);
        check("s6_pc_kept", 64'(PCounter), 64'h0008);
        check("s6_idle", 64'(busy), 64'h0);
        saw = 1'b0;
        repeat (8) begin
            if (imem_req_valid || busy) saw = 1'b1;
            tick();
        end
        check("s6_no_requests", 64'(saw), 64'h0);
        check("s6_misalign_sticky", 64'(misalign_err), 64'h1);
        halt = 1'b1;
`else
        expect_fetch(16'h0042, 32'hA5A5_0042, 1'b1);
        saw             = 1'b0;
        halt            = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 16'h0042;
        tick();
        redirect_valid = 1'b0;
        halt           = 1'b1;
        check("s6_misalign_tied", 64'(misalign_err), 64'h0);
        check("s6_pc_loaded", 64'(PCounter), 64'h0042);
        wait_idle();
        check("s6_pc_after", 64'(PCounter), 64'h0046 | 64'(saw));
`endif

        repeat (4) tick();
        check("leftover_requests", 64'(exp_addr.size()), 64'd0);
        check("leftover_instrs", 64'(exp_pc.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the program-counter datapath and owns the single-outstanding handshake to instruction memory.
- Issues a fetch at `PCounter` and advances it by 4, or loads the branch target when a redirect is taken.
- Kills in-flight or held fetches that a redirect makes stale.
- Sits between the PC logic and the decode stage, and presents one instruction at a time with valid/ready.

Parameters:
- DATA_WIDTH, 16, width of PC and memory address.
- INSTR_WIDTH, 32, width of the instruction word.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- halt  in  1  blocks new fetch start while high
- redirect_valid  in  1  branch/jump taken (PCSrc)
- redirect_target  in  DATA_WIDTH  branch target (PC + ImmExt, computed externally)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  DATA_WIDTH  fetch address
- imem_rsp_valid  in  1  response data valid (one cycle, exactly one per accepted request)
- imem_rsp_data  in  INSTR_WIDTH  fetched instruction
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode accepts instruction
- instr  out  INSTR_WIDTH  instruction word
- instr_pc  out  DATA_WIDTH  address of the presented instruction
- PCounter  out  DATA_WIDTH  next fetch PC
- busy  out  1  state != IDLE
- misalign_err  out  1  sticky misalignment flag (see Optional Feature)

Behaviour:
- Reset (rst low, asynchronous):
  - Outputs: state=IDLE, PCounter=RESET_PC, instr=0, instr_pc=0, instr_valid=0, imem_req_valid=0, misalign_err=0.
  - Internal: kill=0, req_pc=0.
  - Reset mid-operation abandons any outstanding request. Memory is reset together with this block, so no stray response arrives.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: go to REQ next cycle if halt=0; otherwise remain.
- REQ:
  - Drive imem_req_valid=1 and imem_addr=PCounter (combinational from PCounter).
  - On valid&ready: req_pc<=PCounter; PCounter<=PCounter+4, wrapping modulo 2^DATA_WIDTH; go to WAIT.
  - The request is held until accepted; halt is ignored in REQ.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid with kill=1: discard the data, clear kill, go to REQ.
  - On imem_rsp_valid with kill=0: instr<=imem_rsp_data, instr_pc<=req_pc, instr_valid<=1, go to HOLD.
- HOLD:
  - instr, instr_pc and instr_valid stay stable until instr_ready=1.
  - On handshake: instr_valid<=0; go to IDLE if halt=1, else REQ.
- Latency: instr_valid rises the cycle after imem_rsp_valid. Best-case throughput is one instruction per 3 cycles (REQ accepted, response, HOLD accepted).
- Redirect (redirect_valid=1, any state except IDLE-with-halt):
  - PCounter<=redirect_target; this has priority over the +4 increment.
  - REQ, not accepted: imem_addr switches to the target next cycle. An address change while unaccepted is permitted on redirect only.
  - REQ, accepted the same cycle: the issued fetch is stale; set kill=1 and go to WAIT.
  - WAIT, no response: set kill=1.
  - WAIT, response the same cycle: discard the response, go to REQ.
  - HOLD: flush (instr_valid<=0), go to REQ, even if instr_ready=1 the same cycle.
  - IDLE: PCounter is updated; the state transition is unaffected.
- Only redirect_target is used; low bits are not masked.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_target[1:0]!=0 does not update PCounter.
  - misalign_err<=1, sticky until reset.
  - Any held instruction is flushed.
  - FSM goes to IDLE and stays there; an outstanding request is drained first, with its response discarded.
- Undefined: misalign_err tied 0; the target is loaded unchanged.

Test Plan:
- Reset, RESET_PC=0, memory always ready, 1-cycle response, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8; instr_pc matches each; instr_valid pulses every 3 cycles.
- Redirect to 0x0040 asserted in HOLD with instr_pc=0x0004 -> instr_valid drops next cycle; next imem_addr=0x0040; instr 0x0004 is never accepted.
- Redirect to 0x0100 while in WAIT for address 0x0008, response arriving 2 cycles later -> that response is discarded; next request addr=0x0100; instr_pc=0x0100.
- PCounter=0xFFFC, no redirect -> next request at 0xFFFC, then 0x0000 (wrap).
- instr_ready held low 5 cycles in HOLD -> instr/instr_pc stable; no new request; halt=1 on acceptance -> busy=0, PCounter unchanged.
- PC_ALIGN_CHECK_EN defined, redirect to 0x0042 -> misalign_err=1, PCounter unchanged, no further imem requests until reset.
